uart_rx_pkt_ctrl: RTL

//  Packet controller sitting behind the UART receiver FSM. Consumes the receiver's byte strobe
//  (rx_done_tick/dout) and the 16x oversample tick. Frames bytes as SOF | LEN | PAYLOAD[LEN] | CSUM.

---
 rtl/uart_rx_pkt_ctrl_pkg.sv | 23 ++
 rtl/uart_pkt_buf.sv | 30 +++
 rtl/uart_rx_pkt_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkt_ctrl_pkg.sv
// Shared definitions for the UART packet path: default start-of-frame byte,
// error cause codes and controller state encodings.
package uart_rx_pkt_ctrl_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'h7E;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_BADLEN  = 3'd1,
        ERR_CSUM    = 3'd2,
        ERR_TIMEOUT = 3'd3,
        ERR_OVERRUN = 3'd4
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_e;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload store for one packet: DEPTH x 8 register array, one synchronous
// write port and one asynchronous read port.
module uart_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    logic [7:0] mem [DEPTH];

    // NOTE: the array has no reset; contents are only read after being written
    // for the current packet, so clearing them would just cost flops.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < DEPTH_A)) begin
            mem[wr_addr[IW-1:0]] <= wr_data;
        end
    end

    assign rd_data = (rd_addr < DEPTH_A) ? mem[rd_addr[IW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Store-and-forward packet controller behind the UART receiver: frames
// SOF | LEN | PAYLOAD | CSUM and releases payload only after the checksum passes.
module uart_rx_pkt_ctrl
    import uart_rx_pkt_ctrl_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE      = SOF_DEFAULT,
    parameter int         MAX_LEN       = 16,
    parameter int         TIMEOUT_TICKS = 480
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [2:0] err_code,
    output logic       busy
);

    localparam int PW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_TICKS - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_TICKS);

    state_e        state, state_next;
    err_code_e     err_q, err_d;
    logic [PW-1:0] len_q, wr_ptr, rd_ptr;
    logic [PW-1:0] len_m1, rd_next, rd_addr;
    logic [7:0]    sum_q, csum_total, rd_data;
    logic [TW-1:0] tmo_cnt;
    logic          len_ok, csum_ok, tmo_active, tmo_hit, xfer, wr_en;
    logic          m_valid_d, m_last_d, pkt_ok_d, pkt_err_d;
    logic [7:0]    m_data_d;

    assign len_m1     = len_q - PW'(1);
    assign rd_next    = rd_ptr + PW'(1);
    assign csum_total = sum_q + rx_data;
    assign len_ok     = (rx_data != 8'h00) && (rx_data <= MAX_LEN_B);
    assign csum_ok    = (csum_total == 8'h00);
    assign xfer       = m_valid & m_ready;
    assign tmo_active = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
    // A byte in the same cycle as a tick wins, so the tick never completes a timeout.
    assign tmo_hit    = tmo_active & s_tick & ~rx_done_tick & (tmo_cnt == TMO_LAST);
    assign err_code   = err_q;

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (PW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (rx_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (rx_done_tick && (rx_data == SOF_BYTE)) state_next = ST_LEN;
            end
            ST_LEN: begin
                if (rx_done_tick)  state_next = len_ok ? ST_PAYLOAD : ST_IDLE;
                else if (tmo_hit)  state_next = ST_IDLE;
            end
            ST_PAYLOAD: begin
                if (rx_done_tick && (wr_ptr == len_m1)) state_next = ST_CSUM;
                else if (tmo_hit)                       state_next = ST_IDLE;
            end
            ST_CSUM: begin
                if (rx_done_tick)  state_next = csum_ok ? ST_DRAIN : ST_IDLE;
                else if (tmo_hit)  state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                if (xfer && m_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        m_data_d  = m_data;
        m_valid_d = m_valid;
        m_last_d  = m_last;
        pkt_ok_d  = 1'b0;
        pkt_err_d = 1'b0;
        err_d     = err_q;
        wr_en     = 1'b0;
        rd_addr   = rd_next;
        unique case (state)
            ST_LEN: begin
                if (rx_done_tick) begin
                    if (!len_ok) begin
                        pkt_err_d = 1'b1;
                        err_d     = ERR_BADLEN;
                    end
                end else if (tmo_hit) begin
                    pkt_err_d = 1'b1;
                    err_d     = ERR_TIMEOUT;
                end
            end
            ST_PAYLOAD: begin
                if (rx_done_tick) begin
                    wr_en = 1'b1;
                end else if (tmo_hit) begin
                    pkt_err_d = 1'b1;
                    err_d     = ERR_TIMEOUT;
                end
            end
            ST_CSUM: begin
                rd_addr = '0;
                if (rx_done_tick) begin
                    if (csum_ok) begin
                        pkt_ok_d  = 1'b1;
                        m_valid_d = 1'b1;
                        m_data_d  = rd_data;
                        m_last_d  = (len_q == PW'(1));
                    end else begin
                        pkt_err_d = 1'b1;
                        err_d     = ERR_CSUM;
                    end
                end else if (tmo_hit) begin
                    pkt_err_d = 1'b1;
                    err_d     = ERR_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                if (rx_done_tick) begin
                    pkt_err_d = 1'b1;
                    err_d     = ERR_OVERRUN;
                end
                if (xfer) begin
                    if (m_last) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                    end else begin
                        m_data_d = rd_data;
                        m_last_d = (rd_next == len_m1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            pkt_ok  <= 1'b0;
            pkt_err <= 1'b0;
            err_q   <= ERR_NONE;
            busy    <= 1'b0;
            len_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            sum_q   <= '0;
            tmo_cnt <= '0;
        end else begin
            m_data  <= m_data_d;
            m_valid <= m_valid_d;
            m_last  <= m_last_d;
            pkt_ok  <= pkt_ok_d;
            pkt_err <= pkt_err_d;
            err_q   <= err_d;
            busy    <= (state_next != ST_IDLE);

            unique case (state)
                ST_LEN: begin
                    if (rx_done_tick && len_ok) begin
                        len_q  <= rx_data[PW-1:0];
                        sum_q  <= rx_data;
                        wr_ptr <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_done_tick) begin
                        sum_q  <= csum_total;
                        wr_ptr <= wr_ptr + PW'(1);
                    end
                end
                ST_CSUM: begin
                    if (rx_done_tick && csum_ok) rd_ptr <= '0;
                end
                ST_DRAIN: begin
                    if (xfer && !m_last) rd_ptr <= rd_next;
                end
                default: ;
            endcase

            // Counter sits at zero outside the byte-collecting states, which also clears it on entry to LEN.
            if (!tmo_active || rx_done_tick || tmo_hit) begin
                tmo_cnt <= '0;
            end else if (s_tick && (tmo_cnt != TMO_MAX)) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

endmodule
